// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one multiplier among NREQ valid/ready clients.
// An in-order tag FIFO remembers each request's owner so responses route back to it.
module mul_share_arb #(
   parameter int unsigned DWIDTH    = 64,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAX_OUTST = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*DWIDTH-1:0]     req_a,
   input  logic [NREQ*DWIDTH-1:0]     req_b,
   output logic [NREQ-1:0]            resp_valid,
   input  logic [NREQ-1:0]            resp_ready,
   output logic [DWIDTH-1:0]          resp_y,
   output logic                       m_req_valid,
   input  logic                       m_req_ready,
   output logic [DWIDTH-1:0]          m_req_a,
   output logic [DWIDTH-1:0]          m_req_b,
   input  logic                       m_resp_valid,
   output logic                       m_resp_ready,
   input  logic [DWIDTH-1:0]          m_resp_y,
   output logic [$clog2(MAX_OUTST):0] outstanding,
   output logic                       err_orphan
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned PW = $clog2(MAX_OUTST);
   localparam int unsigned CW = PW + 1;

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          lock_vld_q, lock_vld_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [IW-1:0] tag_q [MAX_OUTST];

   logic [DWIDTH-1:0] op_a [NREQ];
   logic [DWIDTH-1:0] op_b [NREQ];
   logic [NREQ-1:0]   elig;
   logic [IW-1:0]     grant, idx, head;
   logic              any_elig, push, pop, fifo_empty;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign op_a[i] = req_a[i*DWIDTH +: DWIDTH];
      assign op_b[i] = req_b[i*DWIDTH +: DWIDTH];
   end

   // Eligibility is gated on the registered count, so a same-cycle pop never frees a slot early.
   always_comb begin
      elig     = (cnt_q < CW'(MAX_OUTST)) ? req_valid : '0;
      grant    = rr_ptr_q;
      any_elig = 1'b0;
      idx      = '0;
      if (lock_vld_q) begin
         grant    = lock_idx_q;
         any_elig = elig[lock_idx_q];
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(rr_ptr_q) + k) % NREQ);
            if (!any_elig && elig[idx]) begin
               grant    = idx;
               any_elig = 1'b1;
            end
         end
      end
   end

   assign m_req_valid = any_elig;
   assign m_req_a     = op_a[grant];
   assign m_req_b     = op_b[grant];
   assign push        = any_elig & m_req_ready;

   always_comb begin
      req_ready = '0;
      if (push) req_ready[grant] = 1'b1;
   end

   assign fifo_empty = (cnt_q == '0);
   assign head       = tag_q[rd_ptr_q];
   assign resp_y     = m_resp_y;

   // With no owner on record the response is an orphan: accept and drop it.
   always_comb begin
      resp_valid   = '0;
      m_resp_ready = 1'b1;
      if (!fifo_empty) begin
         resp_valid[head] = m_resp_valid;
         m_resp_ready     = resp_ready[head];
      end
   end

   assign pop = ~fifo_empty & m_resp_valid & m_resp_ready;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      if (push) rr_ptr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
      lock_vld_d = any_elig & ~m_req_ready;
      lock_idx_d = grant;
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      err_d      = err_q | (fifo_empty & m_resp_valid);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_idx_q <= lock_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_q[wr_ptr_q] <= grant;
   end

   assign outstanding = cnt_q;
   assign err_orphan  = err_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of owners and expected products.
module tb_mul_share_arb;
   localparam int DW = 64;
   localparam int NR = 4;
   localparam int MO = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NR-1:0]      req_valid, req_ready, resp_valid, resp_ready;
   logic [NR*DW-1:0]   req_a, req_b;
   logic [DW-1:0]      resp_y, m_req_a, m_req_b, m_resp_y;
   logic               m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, err_orphan;
   logic [3:0]         outstanding;

   always #5 clk = ~clk;

   mul_share_arb #(.DWIDTH(DW), .NREQ(NR), .MAX_OUTST(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_a(m_req_a), .m_req_b(m_req_b),
      .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_y(m_resp_y),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) * $bitstoreal(b));
   endfunction

   function automatic logic [63:0] rnd_op();
      return $realtobits($itor($urandom_range(4000, 1)) / 16.0);
   endfunction

   function automatic int onehot_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   // ---------------- environment: clients and a fake in-order multiplier ----------------
   typedef struct {
      logic [63:0] y;
      int          t;
   } mop_t;

   mop_t          mq[$];
   int            req_pct = 0, mrdy_pct = 100, resp_pct = 100, rrdy_pct = 100;
   int            lat_lo = 3, lat_hi = 3, cyc = 0;
   logic [NR-1:0] rrdy_low = '0;
   bit            orphan_req = 0, orphan_now = 0, mv_hold = 0, rst_val = 0;
   bit            pend[NR];
   logic [63:0]   ca[NR], cb[NR];
   bit            acc_req = 0, acc_resp = 0, mrv_c = 0, rst_c = 0;
   logic [63:0]   acc_a, acc_b;
   logic [NR-1:0] took = '0;

   task automatic step();
      mop_t tmp;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_c) begin
         mq.delete();
         mv_hold = 0;
      end else begin
         if (acc_resp && !orphan_now) tmp = mq.pop_front();
         if (acc_req) begin
            tmp.y = fmul(acc_a, acc_b);
            tmp.t = cyc - 1 + $urandom_range(lat_hi, lat_lo);
            mq.push_back(tmp);
         end
         mv_hold = mrv_c && !acc_resp;
      end
      for (int i = 0; i < NR; i++) if (took[i]) pend[i] = 0;

      @(negedge clk);
      rst_n = rst_val;
      for (int i = 0; i < NR; i++) begin
         if (!pend[i] && $urandom_range(99) < req_pct) begin
            pend[i] = 1;
            ca[i]   = rnd_op();
            cb[i]   = rnd_op();
         end
         req_valid[i]         = pend[i];
         req_a[i*DW +: DW]    = ca[i];
         req_b[i*DW +: DW]    = cb[i];
         resp_ready[i]        = !rrdy_low[i] && ($urandom_range(99) < rrdy_pct);
      end
      m_req_ready = ($urandom_range(99) < mrdy_pct);
      orphan_now  = 0;
      if (mq.size() > 0 && (mv_hold || (cyc >= mq[0].t && $urandom_range(99) < resp_pct))) begin
         m_resp_valid = 1'b1;
         m_resp_y     = mq[0].y;
      end else if (orphan_req && mq.size() == 0) begin
         m_resp_valid = 1'b1;
         m_resp_y     = rnd_op();
         orphan_now   = 1;
         orphan_req   = 0;
      end else begin
         m_resp_valid = 1'b0;
         m_resp_y     = {$urandom, $urandom};
      end
      #3;
      acc_req  = m_req_valid & m_req_ready;
      acc_a    = m_req_a;
      acc_b    = m_req_b;
      acc_resp = m_resp_valid & m_resp_ready;
      mrv_c    = m_resp_valid;
      rst_c    = rst_n;
      took     = req_valid & req_ready;
   endtask

   function automatic bit env_idle();
      for (int i = 0; i < NR; i++) if (pend[i]) return 0;
      return mq.size() == 0;
   endfunction

   task automatic wait_idle(input string name);
      bit done = 0;
      req_pct = 0; resp_pct = 100; rrdy_pct = 100; mrdy_pct = 100; rrdy_low = '0;
      for (int k = 0; k < 300 && !done; k++) begin
         step();
         done = env_idle();
      end
      if (!done) check({name, "_drain_timeout"}, 64'd0, 64'd1);
      step();
   endtask

   // ---------------- reference model, compared every cycle ----------------
   initial begin : model
      int            rr, li, g, cnt, o;
      bit            lk, err, armed, mv, push, pop, r;
      int            own[$];
      logic [63:0]   ys[$];
      logic [NR-1:0] e, exp_rr, exp_rv;
      logic [63:0]   ga, gb, dummy;
      rr = 0; li = 0; lk = 0; err = 0; armed = 0;
      forever begin
         @(negedge clk);
         #2;
         cnt = own.size();
         e   = (cnt < MO) ? req_valid : '0;
         mv  = 0;
         g   = 0;
         if (lk) begin
            g  = li;
            mv = e[g];
         end else begin
            for (int k = 0; k < NR; k++) begin
               if (!mv && e[(rr + k) % NR]) begin
                  g  = (rr + k) % NR;
                  mv = 1;
               end
            end
         end
         ga     = req_a[g*DW +: DW];
         gb     = req_b[g*DW +: DW];
         exp_rr = (mv && m_req_ready) ? NR'(1) << g : '0;
         push   = mv && m_req_ready;
         exp_rv = '0;
         pop    = 0;
         o      = (cnt > 0) ? own[0] : 0;
         if (cnt > 0 && m_resp_valid) exp_rv = NR'(1) << o;
         if (cnt > 0) pop = m_resp_valid && resp_ready[o];
         if (armed) begin
            check("m_req_valid", 64'(m_req_valid), 64'(mv));
            if (mv) begin
               check("m_req_a", m_req_a, ga);
               check("m_req_b", m_req_b, gb);
            end
            check("req_ready", 64'(req_ready), 64'(exp_rr));
            check("resp_valid", 64'(resp_valid), 64'(exp_rv));
            check("m_resp_ready", 64'(m_resp_ready), (cnt > 0) ? 64'(resp_ready[o]) : 64'd1);
            if (cnt > 0 && m_resp_valid) check("resp_y", resp_y, ys[0]);
            check("outstanding", 64'(outstanding), 64'(cnt));
            check("err_orphan", 64'(err_orphan), 64'(err));
         end
         r = rst_n;
         @(posedge clk);
         if (!r) begin
            own.delete(); ys.delete();
            rr = 0; lk = 0; li = 0; err = 0; armed = 1;
         end else begin
            if (cnt == 0 && m_resp_valid) err = 1;
            if (pop) begin
               o     = own.pop_front();
               dummy = ys.pop_front();
            end
            if (push) begin
               own.push_back(g);
               ys.push_back(fmul(ga, gb));
               rr = (g + 1) % NR;
            end
            lk = mv && !m_req_ready;
            li = g;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   // ---------------- directed scenarios and random traffic ----------------
   initial begin : stim
      int          exp_g[6];
      bit          seen;
      logic [63:0] y0, a2, b2;
      int          first_pend;
      exp_g = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
      m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_y = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 0; ca[i] = '0; cb[i] = '0;
      end

      rst_val = 0; mrdy_pct = 0;
      step(); step();
      rst_val = 1;
      step();
      check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_m_resp_ready", 64'(m_resp_ready), 64'd1);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err_orphan", 64'(err_orphan), 64'd0);

      // Round robin: all four clients request continuously.
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1; ca[i] = rnd_op(); cb[i] = rnd_op();
      end
      ca[0] = 64'h4000000000000000;
      cb[0] = 64'h4008000000000000;
      req_pct = 100; mrdy_pct = 100; resp_pct = 100; rrdy_pct = 100; lat_lo = 3; lat_hi = 3;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k < 6) check("rr_grant", 64'(onehot_idx(req_ready)), 64'(exp_g[k]));
         if (!seen && resp_valid != '0) begin
            check("rr_first_resp_owner", 64'(resp_valid), 64'd1);
            check("rr_first_resp_y", resp_y, 64'h4018000000000000);
            seen = 1;
         end
      end
      check("rr_first_resp_seen", 64'(seen), 64'd1);
      wait_idle("rr");

      // Grant lock: client 2 stalls, client 0 arrives during the stall.
      mrdy_pct = 0;
      pend[2] = 1; ca[2] = rnd_op(); cb[2] = rnd_op(); a2 = ca[2]; b2 = cb[2];
      step();
      check("lock_valid", 64'(m_req_valid), 64'd1);
      check("lock_a0", m_req_a, a2);
      pend[0] = 1; ca[0] = rnd_op(); cb[0] = rnd_op();
      for (int k = 0; k < 3; k++) begin
         step();
         check("lock_hold_a", m_req_a, a2);
         check("lock_hold_b", m_req_b, b2);
      end
      mrdy_pct = 100;
      step();
      check("lock_grant2", 64'(req_ready), 64'h4);
      step();
      check("lock_then0", 64'(req_ready), 64'h1);
      wait_idle("lock");

      // Full: withhold responses until eight are in flight.
      resp_pct = 0; req_pct = 100; lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < MO; k++) begin
         step();
         check("full_fill_accept", 64'(m_req_valid & m_req_ready), 64'd1);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         check("full_outstanding", 64'(outstanding), 64'd8);
         check("full_no_req", 64'(m_req_valid), 64'd0);
      end
      resp_pct = 100;
      step();
      check("full_pop", 64'(acc_resp), 64'd1);
      check("full_pop_no_req", 64'(m_req_valid), 64'd0);
      resp_pct = 0;
      step();
      check("full_after_pop_req", 64'(m_req_valid & m_req_ready), 64'd1);
      check("full_after_pop_cnt", 64'(outstanding), 64'd7);
      wait_idle("full");

      // Response backpressure on client 1.
      lat_lo = 3; lat_hi = 3; rrdy_low = 4'b0010;
      pend[1] = 1; ca[1] = rnd_op(); cb[1] = rnd_op();
      seen = 0; y0 = '0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (resp_valid != '0) begin
            seen = 1;
            y0   = resp_y;
         end
      end
      check("bp_seen", 64'(seen), 64'd1);
      check("bp_y", y0, fmul(ca[1], cb[1]));
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_m_resp_ready", 64'(m_resp_ready), 64'd0);
         check("bp_resp_valid", 64'(resp_valid), 64'h2);
         check("bp_resp_y", resp_y, y0);
      end
      rrdy_low = '0; rrdy_pct = 100;
      step();
      check("bp_release", 64'(m_resp_ready & resp_valid[1]), 64'd1);
      wait_idle("bp");

      // Orphan response with nothing outstanding.
      orphan_req = 1;
      step();
      check("orphan_drain", 64'(m_resp_ready), 64'd1);
      check("orphan_no_resp", 64'(resp_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("orphan_sticky", 64'(err_orphan), 64'd1);
      end

      // Reset with five in flight.
      resp_pct = 0; req_pct = 100;
      for (int k = 0; k < 5; k++) step();
      req_pct = 0;
      check("mid_pre_cnt", 64'(outstanding), 64'd4);
      rst_val = 0;
      step();
      check("mid_in_rst_cnt", 64'(outstanding), 64'd5);
      rst_val = 1;
      step();
      check("mid_cnt", 64'(outstanding), 64'd0);
      check("mid_resp_valid", 64'(resp_valid), 64'd0);
      check("mid_err_cleared", 64'(err_orphan), 64'd0);
      first_pend = -1;
      for (int i = NR - 1; i >= 0; i--) if (pend[i]) first_pend = i;
      check("mid_rr_from0", 64'(onehot_idx(req_ready)), 64'(first_pend));
      wait_idle("mid");

      // Random traffic with occasional resets.
      req_pct = 40; mrdy_pct = 70; resp_pct = 70; rrdy_pct = 70; lat_lo = 1; lat_hi = 4;
      for (int k = 0; k < 3000; k++) begin
         rst_val = ($urandom_range(999) != 0);
         step();
      end
      rst_val = 1;
      wait_idle("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
